// File: rtl/block_ppl_mult.sv
// rtl/block_ppl_mult.sv - pipelined signed x sign-magnitude coefficient multiplier for the IDCT datapath
// Optional macro DESCALE_EN adds a rounding >>>7 stage (latency 3 -> 4).
module block_ppl_mult #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data,
    input  logic [COEF_W-1:0] biSignal,
    output logic              out_valid,
    output logic [OUT_W-1:0]  outputData
);

    localparam int MAG_W = COEF_W - 1;
    localparam int L1_N  = (MAG_W + 1) / 2;

    // S1 registers
    logic              r_s1_valid;
    logic              r_s1_sign;
    logic [DATA_W-1:0] r_s1_data;
    logic [MAG_W-1:0]  r_s1_mag;

    // S2 registers
    logic              r_s2_valid;
    logic              r_s2_sign;
    logic [OUT_W-1:0]  r_s2_sum_lo;
    logic [OUT_W-1:0]  r_s2_sum_hi;

    logic [OUT_W-1:0]  w_data_ext;
    logic [OUT_W-1:0]  w_pp [MAG_W];
    logic [OUT_W-1:0]  w_l1 [L1_N];
    logic [OUT_W-1:0]  w_sum_lo;
    logic [OUT_W-1:0]  w_sum_hi;
    logic [OUT_W-1:0]  w_prod;
    logic [OUT_W-1:0]  w_result;

    assign w_data_ext = {{(OUT_W-DATA_W){r_s1_data[DATA_W-1]}}, r_s1_data};

    // Partial products and a two-level adder tree: pairs first, then two halves.
    always_comb begin
        for (int k = 0; k < MAG_W; k++) begin
            w_pp[k] = r_s1_mag[k] ? (w_data_ext << k) : '0;
        end
        for (int i = 0; i < L1_N; i++) begin
            if (2 * i + 1 < MAG_W) begin
                w_l1[i] = w_pp[2*i] + w_pp[2*i+1];
            end else begin
                w_l1[i] = w_pp[2*i];
            end
        end
        w_sum_lo = '0;
        w_sum_hi = '0;
        for (int i = 0; i < L1_N; i++) begin
            if (i < L1_N / 2) begin
                w_sum_lo = w_sum_lo + w_l1[i];
            end else begin
                w_sum_hi = w_sum_hi + w_l1[i];
            end
        end
    end

    // Negating a zero product yields zero, so "negative zero" needs no special case.
    assign w_prod   = r_s2_sum_lo + r_s2_sum_hi;
    assign w_result = r_s2_sign ? (~w_prod + 1'b1) : w_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_data   <= '0;
            r_s1_mag    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_sum_lo <= '0;
            r_s2_sum_hi <= '0;
        end else begin
            r_s1_valid  <= in_valid;
            r_s1_sign   <= biSignal[COEF_W-1];
            r_s1_data   <= data;
            r_s1_mag    <= biSignal[MAG_W-1:0];
            r_s2_valid  <= r_s1_valid;
            r_s2_sign   <= r_s1_sign;
            r_s2_sum_lo <= w_sum_lo;
            r_s2_sum_hi <= w_sum_hi;
        end
    end

`ifdef DESCALE_EN
    localparam int DESCALE_SH = 7;

    logic                    r_s3_valid;
    logic [OUT_W-1:0]        r_s3_result;
    logic signed [OUT_W-1:0] w_rounded;

    // Round half up before the arithmetic shift.
    assign w_rounded = $signed(r_s3_result + OUT_W'(1 << (DESCALE_SH - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid  <= 1'b0;
            r_s3_result <= '0;
            out_valid   <= 1'b0;
            outputData  <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_result <= w_result;
            end
            out_valid <= r_s3_valid;
            if (r_s3_valid) begin
                outputData <= OUT_W'(w_rounded >>> DESCALE_SH);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            outputData <= '0;
        end else begin
            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                outputData <= w_result;
            end
        end
    end
`endif

endmodule

// File: tb/tb_block_ppl_mult.sv
// tb/tb_block_ppl_mult.sv - directed self-checking bench for block_ppl_mult
module tb_block_ppl_mult;

`ifdef DESCALE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  data = '0;
    logic [7:0]  biSignal = '0;
    logic        out_valid;
    logic [15:0] outputData;

    int checks = 0;
    int failures = 0;

    logic        vin_v [16];
    logic [7:0]  vin_d [16];
    logic [7:0]  vin_c [16];
    logic        obs_v [32];
    logic [15:0] obs_d [32];

    block_ppl_mult dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .data       (data),
        .biSignal   (biSignal),
        .out_valid  (out_valid),
        .outputData (outputData)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] scale(input int raw);
`ifdef DESCALE_EN
        int r;
        r = (raw + 64) >>> 7;
        return 16'(r);
`else
        return 16'(raw);
`endif
    endfunction

    // Drives n samples one per cycle and records outputs at each negedge; sample i lands at index i+LAT.
    task automatic run(input int n);
        for (int c = 0; c <= n + LAT; c++) begin
            @(negedge clk);
            obs_v[c] = out_valid;
            obs_d[c] = outputData;
            if (c < n) begin
                in_valid = vin_v[c];
                data     = vin_d[c];
                biSignal = vin_c[c];
            end else begin
                in_valid = 1'b0;
                data     = '0;
                biSignal = '0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (outputData !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0000", outputData);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_valid cyc=%0d got=%b exp=0", c, out_valid);
            end
        end
    endtask

    task automatic test_coef_sequence;
        logic [7:0] coefs [6];
        int         raws  [6];
        coefs = '{8'd64, 8'd83, 8'd89, 8'd75, 8'd50, 8'd36};
        raws  = '{192, 249, 267, 225, 150, 108};
        for (int i = 0; i < 6; i++) begin
            vin_v[i] = 1'b1;
            vin_d[i] = 8'd3;
            vin_c[i] = coefs[i];
        end
        run(6);
        checks++;
        if (obs_v[LAT-1] !== 1'b0) begin
            failures++;
            $display("FAIL seq_early_valid got=%b exp=0", obs_v[LAT-1]);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_v[i+LAT] !== 1'b1 || obs_d[i+LAT] !== scale(raws[i])) begin
                failures++;
                $display("FAIL seq_result i=%0d got=%b/%h exp=1/%h", i, obs_v[i+LAT], obs_d[i+LAT], scale(raws[i]));
            end
        end
        checks++;
        if (obs_v[6+LAT] !== 1'b0) begin
            failures++;
            $display("FAIL seq_tail_valid got=%b exp=0", obs_v[6+LAT]);
        end
    endtask

    task automatic test_signs;
        int raws [3];
        raws = '{-225, -16256, 16256};
        vin_v[0] = 1'b1; vin_d[0] = 8'd3;  vin_c[0] = 8'hCB;
        vin_v[1] = 1'b1; vin_d[1] = 8'h80; vin_c[1] = 8'h7F;
        vin_v[2] = 1'b1; vin_d[2] = 8'h80; vin_c[2] = 8'hFF;
        run(3);
`ifndef DESCALE_EN
        raws[0] = int'($signed(16'hFF1F));
        raws[1] = int'($signed(16'hC080));
        raws[2] = int'($signed(16'h3F80));
`endif
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_v[i+LAT] !== 1'b1 || obs_d[i+LAT] !== scale(raws[i])) begin
                failures++;
                $display("FAIL sign_result i=%0d got=%b/%h exp=1/%h", i, obs_v[i+LAT], obs_d[i+LAT], scale(raws[i]));
            end
        end
    endtask

    task automatic test_zero_and_bubble;
        logic       exp_v [4];
        logic [15:0] exp_d [4];
        vin_v[0] = 1'b1; vin_d[0] = 8'hFB; vin_c[0] = 8'h80;
        vin_v[1] = 1'b1; vin_d[1] = 8'd7;  vin_c[1] = 8'd64;
        vin_v[2] = 1'b0; vin_d[2] = 8'd5;  vin_c[2] = 8'd83;
        vin_v[3] = 1'b1; vin_d[3] = 8'd0;  vin_c[3] = 8'h4B;
        exp_v = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_d = '{16'h0000, scale(448), scale(448), 16'h0000};
        run(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_v[i+LAT] !== exp_v[i] || obs_d[i+LAT] !== exp_d[i]) begin
                failures++;
                $display("FAIL zero_bubble i=%0d got=%b/%h exp=%b/%h", i, obs_v[i+LAT], obs_d[i+LAT], exp_v[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_inflight;
        @(negedge clk);
        in_valid = 1'b1; data = 8'd3; biSignal = 8'd64;
        @(negedge clk);
        in_valid = 1'b1; data = 8'd3; biSignal = 8'd83;
        @(negedge clk);
        in_valid = 1'b0; data = '0; biSignal = '0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || outputData !== 16'h0000) begin
                failures++;
                $display("FAIL inflight_rst cyc=%0d got=%b/%h exp=0/0000", c, out_valid, outputData);
            end
        end
        rst = 1'b0;
        vin_v[0] = 1'b1; vin_d[0] = 8'd3; vin_c[0] = 8'd89;
        run(1);
        for (int c = 0; c < LAT; c++) begin
            checks++;
            if (obs_v[c] !== 1'b0) begin
                failures++;
                $display("FAIL inflight_leak cyc=%0d got=%b exp=0", c, obs_v[c]);
            end
        end
        checks++;
        if (obs_v[LAT] !== 1'b1 || obs_d[LAT] !== scale(267)) begin
            failures++;
            $display("FAIL after_rst_result got=%b/%h exp=1/%h", obs_v[LAT], obs_d[LAT], scale(267));
        end
    endtask

`ifdef DESCALE_EN
    task automatic test_descale;
        vin_v[0] = 1'b1; vin_d[0] = 8'd3; vin_c[0] = 8'd64;
        vin_v[1] = 1'b1; vin_d[1] = 8'd3; vin_c[1] = 8'hD3;
        run(2);
        checks++;
        if (obs_v[3] !== 1'b0) begin
            failures++;
            $display("FAIL descale_latency got=%b exp=0", obs_v[3]);
        end
        checks++;
        if (obs_v[4] !== 1'b1 || obs_d[4] !== 16'h0002) begin
            failures++;
            $display("FAIL descale_pos got=%b/%h exp=1/0002", obs_v[4], obs_d[4]);
        end
        checks++;
        if (obs_v[5] !== 1'b1 || obs_d[5] !== 16'hFFFE) begin
            failures++;
            $display("FAIL descale_neg got=%b/%h exp=1/fffe", obs_v[5], obs_d[5]);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_coef_sequence;
        test_signs;
        test_zero_and_bubble;
        test_reset_inflight;
`ifdef DESCALE_EN
        test_descale;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
